// File: rtl/data_synchronizer_pkg.sv
// Shared defaults for the multi-cycle-path bus synchronizer.
// Keeping them here lets the top and any wrapper agree on sizing.
package data_synchronizer_pkg;

  localparam int DEFAULT_STAGE_COUNT = 2;
  localparam int DEFAULT_BUS_WIDTH   = 4;

endpackage

// File: rtl/data_synchronizer_bit_synchronizer.sv
// Multi-flop level synchronizer for a single asynchronous control bit.
// chain[0] is the only flop sampling the asynchronous input.
module bit_synchronizer #(
  parameter int STAGE_COUNT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGE_COUNT-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGE_COUNT-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGE_COUNT-1];

endmodule

// File: rtl/data_synchronizer.sv
// MCP bus synchronizer: only the valid qualifier is synchronized; its rising
// edge triggers a one-shot capture of the (quasi-static) source bus.
module data_synchronizer
  import data_synchronizer_pkg::*;
#(
  parameter int STAGE_COUNT = DEFAULT_STAGE_COUNT,
  parameter int BUS_WIDTH   = DEFAULT_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 asynchronous_data_valid,
  input  logic [BUS_WIDTH-1:0] asynchronous_data,
  output logic                 Q_pulse_generator,
  output logic [BUS_WIDTH-1:0] synchronous_data,
  output logic                 synchronous_data_valid
);

  logic sync_out;
  logic enable_pulse;

  bit_synchronizer #(
    .STAGE_COUNT(STAGE_COUNT)
  ) u_valid_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(asynchronous_data_valid),
    .sync_out(sync_out)
  );

  assign enable_pulse = sync_out & ~Q_pulse_generator;

  // The bus is only ever sampled under enable_pulse, when the source
  // guarantees it has been stable for the whole synchronizer latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Q_pulse_generator      <= 1'b0;
      synchronous_data       <= '0;
      synchronous_data_valid <= 1'b0;
    end else begin
      Q_pulse_generator      <= sync_out;
      synchronous_data_valid <= enable_pulse;
      if (enable_pulse) begin
        synchronous_data <= asynchronous_data;
      end
    end
  end

endmodule

// File: tb/tb_data_synchronizer.sv
// Directed bench for data_synchronizer: a vector table for reset and a first
// transfer, then hand sequences for held valid, code sweep, hold and reset.
module tb_data_synchronizer;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [3:0] data;
  logic       q_pg;
  logic [3:0] sdata;
  logic       svalid;

  int checks   = 0;
  int failures = 0;

  data_synchronizer #(
    .STAGE_COUNT(2),
    .BUS_WIDTH  (4)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .asynchronous_data_valid(valid),
    .asynchronous_data      (data),
    .Q_pulse_generator      (q_pg),
    .synchronous_data       (sdata),
    .synchronous_data_valid (svalid)
  );

  initial clk = 1'b0;
  always #6 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] d;
    logic       exp_sv;
    logic [3:0] exp_sd;
    logic       exp_q;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise valid with the given word, expect the pulse on the 3rd edge,
  // then drop valid long enough for the next transfer to re-arm.
  task automatic transfer(input logic [3:0] word, input string tag);
    int n;
    n = 0;
    data  = word;
    valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!svalid && n < 10);
    check({tag, "_latency"}, n, 3);
    check({tag, "_data"}, sdata, {28'h0, word});
    tick();
    check({tag, "_width"}, svalid, 0);
    valid = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    int pulses;
    int n;

    vecs[0]  = '{1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'hA, 1'b0, 4'h0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'hA, 1'b0, 4'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'hA, 1'b1, 4'hA, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 4'hA, 1'b0, 4'hA, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 4'hA, 1'b0, 4'hA, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 4'hA, 1'b0, 4'hA, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 4'hA, 1'b0, 4'hA, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'hC, 1'b0, 4'hA, 1'b0};

    reset = 1'b0;
    valid = 1'b1;
    data  = 4'hF;

    for (int i = 0; i < 12; i++) begin
      reset = vecs[i].rst;
      valid = vecs[i].v;
      data  = vecs[i].d;
      tick();
      check($sformatf("vec%0d_svalid", i), svalid, vecs[i].exp_sv);
      check($sformatf("vec%0d_sdata", i), sdata, vecs[i].exp_sd);
      check($sformatf("vec%0d_q", i), q_pg, vecs[i].exp_q);
    end
    repeat (3) tick();

    // Held valid: one pulse only.
    pulses = 0;
    data   = 4'h5;
    valid  = 1'b1;
    repeat (20) begin
      tick();
      if (svalid) pulses++;
    end
    check("held_pulses", pulses, 1);
    check("held_data", sdata, 4'h5);
    valid = 1'b0;
    repeat (5) tick();

    for (int c = 0; c < 16; c++) begin
      transfer(c[3:0], $sformatf("sweep%0d", c));
    end

    // Hold: data changes while valid stays low.
    transfer(4'h3, "hold_cap");
    pulses = 0;
    data   = 4'hC;
    repeat (10) begin
      tick();
      if (svalid) pulses++;
    end
    check("hold_pulses", pulses, 0);
    check("hold_data", sdata, 4'h3);

    // Reset mid-transfer.
    data  = 4'h9;
    valid = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("midrst_q", q_pg, 0);
    check("midrst_svalid", svalid, 0);
    check("midrst_sdata", sdata, 0);
    tick();
    check("midrst_q2", q_pg, 0);
    reset = 1'b1;
    n = 0;
    pulses = 0;
    do begin
      tick();
      n++;
    end while (!svalid && n < 10);
    check("midrst_latency", n, 3);
    check("midrst_data", sdata, 4'h9);
    repeat (10) begin
      tick();
      if (svalid) pulses++;
    end
    check("midrst_extra_pulses", pulses, 0);
    valid = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_synchronizer.md
Name: data_synchronizer

Overview:
Multi-cycle-path (MCP) bus synchronizer that moves a BUS_WIDTH data word from an asynchronous source domain into the clk domain.
- Only the single-bit valid qualifier passes through an STAGE_COUNT-deep flop synchronizer.
- A rising-edge pulse generator on the synchronized valid enables a one-shot capture of the bus.
- Sits at clock-domain crossings between a slow producer and the destination logic.

Parameters:
STAGE_COUNT, 2, number of flops in the valid synchronizer chain (>=2).
BUS_WIDTH, 4, data bus width in bits (>=1).

Ports:
clk  input  1  destination-domain clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset.
asynchronous_data_valid  input  1  source-domain valid level; held high while asynchronous_data is stable.
asynchronous_data  input  BUS_WIDTH  source-domain data; must be stable from valid rise until synchronous_data_valid pulses.
Q_pulse_generator  output  1  pulse-generator flop: synchronized valid delayed by one clk.
synchronous_data  output  BUS_WIDTH  captured data, held until the next capture.
synchronous_data_valid  output  1  registered one-cycle pulse, asserted in the cycle synchronous_data updates.

Behaviour:
- Reset: when reset==0 at a clk rising edge, clear all sync-chain flops, Q_pulse_generator, synchronous_data and synchronous_data_valid to 0. Reset has priority over all other activity.
- Sync chain:
  - sync[0] <= asynchronous_data_valid.
  - sync[k] <= sync[k-1] for k=1..STAGE_COUNT-1.
  - sync_out = sync[STAGE_COUNT-1].
- Pulse generator:
  - Q_pulse_generator <= sync_out.
  - enable_pulse = sync_out & ~Q_pulse_generator (combinational).
- Capture:
  - On enable_pulse, synchronous_data <= asynchronous_data; otherwise hold.
  - synchronous_data_valid <= enable_pulse every cycle, so it is high exactly one cycle per rising edge of valid.
- Latency:
  - Let edge E0 be the first rising edge that samples asynchronous_data_valid=1.
  - sync_out is high after edge E0+STAGE_COUNT-1.
  - synchronous_data and synchronous_data_valid update at edge E0+STAGE_COUNT. With STAGE_COUNT=2 this is the 3rd sampling edge.
- Valid and data are registered on the same edge, so data equals the source word whenever synchronous_data_valid==1.
- A valid level held high for many cycles produces exactly one output pulse. A new pulse requires valid low for at least STAGE_COUNT+1 clk cycles, then high again.
- Valid low: no capture; synchronous_data keeps the last captured word indefinitely.
- A valid glitch shorter than one clk period may or may not be captured. Source protocol forbids it.
- Reset mid-transfer: the chain clears. If valid is still high after reset release, the transfer restarts and produces one pulse after the normal latency.
- No metastability modelling in RTL. The chain flops are the only flops sampling asynchronous inputs; asynchronous_data is never sampled except under enable_pulse.

Decomposition:
- No shared package needed. STAGE_COUNT and BUS_WIDTH are module parameters.
- Natural sub-module: bit_synchronizer (parameter STAGE_COUNT; ports clk, reset, async_in, sync_out), holding the multi-flop chain.
- Pulse generator and data capture register stay in data_synchronizer.

Test Plan:
- Reset: hold reset=0 for one clk with valid=1, data=4'hF -> all outputs 0; no valid pulse during reset.
- Single transfer (clk period 12 ns): data=4'b1010, valid=1 -> synchronous_data_valid high for exactly one cycle at the 3rd sampling edge, with synchronous_data=4'b1010.
- Held valid: keep valid=1 for 20 cycles with data=4'h5 -> exactly one pulse; synchronous_data stays 4'h5.
- Sweep: for all 16 codes 0..15, assert valid, wait for the pulse, compare, drop valid for 50 ns -> 16/16 matches; each pulse one cycle wide.
- Hold: after capturing 4'h3, change data to 4'hC with valid=0 -> synchronous_data remains 4'h3, no pulse.
- Reset mid-transfer: raise valid (data=4'h9), assert reset after 1 edge, release while valid is still 1 -> one pulse after full latency, data=4'h9; Q_pulse_generator is 0 during reset.
